rtc_snapshot_scanner: RTL and testbench
=======================================

Name: rtc_snapshot_scanner

Overview:
- Downstream consumer of the RTC controller's register memory.
- Sequentially reads the RTC shadow registers through the memory's third read port (address out, data in) on each scan request.
- Checks every byte for valid BCD and builds a coherent working snapshot.
- Commits the snapshot to a display-side buffer only at a frame boundary, so the display never shows a torn time/date.

Parameters:
- NUM_REGS, 9: registers scanned at addresses 0..NUM_REGS-1 (sec, min, hour, day, month, year, timer sec, timer min, timer hour); 1..16.
- RD_LAT, 1: cycles from reg_addr change to valid reg_data; 0..3.
- TIMEOUT, 1000000: cycles to wait in PEND for frame_sync before a forced commit; counter is 20 bits wide.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scan_tick  in  1  single-cycle scan request (periodic pulse)
- frame_sync  in  1  single-cycle frame-boundary pulse from the display timing
- reg_addr  out  4  read address into the RTC register memory
- reg_data  in  8  read data from the RTC register memory
- snapshot  out  8*NUM_REGS  committed register bytes; register i is at bits [8i+7:8i]
- bcd_err  out  NUM_REGS  committed per-register flag: a nibble was greater than 9
- busy  out  1  high in every state except IDLE
- updated  out  1  one-cycle pulse on each commit
- forced  out  1  one-cycle pulse when a commit was caused by timeout

Behaviour:
- Reset (async, active-high): all outputs are 0, work buffer is 0, idx=0, pending flag=0, state=IDLE.
- IDLE: on scan_tick, set idx=0, drive reg_addr=0, clear the latency counter, go to READ.
- READ:
  - reg_addr = idx, held stable.
  - After RD_LAT further cycles, reg_data is sampled into work[idx].
  - work_err[idx] = (reg_data[7:4] > 9) | (reg_data[3:0] > 9).
  - If idx == NUM_REGS-1, go to PEND; otherwise idx+1 and reg_addr advances on the same edge.
  - Each register costs RD_LAT+1 cycles; a full scan costs NUM_REGS*(RD_LAT+1) cycles.
  - With RD_LAT=0, sampling happens on the same edge that leaves reg_addr=idx.
- PEND:
  - Waits for frame_sync. The timeout counter starts at 0 on entry.
  - On frame_sync: go to COMMIT.
  - When the counter reaches TIMEOUT-1 with no frame_sync: go to COMMIT and pulse forced.
  - If both occur in the same cycle, it is a normal commit and forced stays 0.
- COMMIT (1 cycle):
  - snapshot <= work, bcd_err <= work_err, updated=1.
  - If the pending flag is set: clear it and restart the scan (go to READ with idx=0).
  - Otherwise go to IDLE.
- Scan requests while busy:
  - scan_tick seen in READ/PEND/COMMIT sets the one-deep pending flag; extra ticks are dropped.
  - scan_tick seen in IDLE starts a scan directly.
- frame_sync outside PEND is ignored.
- snapshot/bcd_err change only in COMMIT. A partially scanned buffer is never visible on the outputs.
- reg_addr stays at its last value in IDLE/PEND (memory reads have no side effects).
- Reset asserted mid-scan: immediate return to IDLE with outputs cleared; no commit occurs.
- Widths: idx is 4 bits; the latency counter is 2 bits; NUM_REGS=16 must wrap correctly at the final index without overflowing idx compares.

Decomposition:
- Shared package `rtc_pkg`: state encoding (IDLE, READ, PEND, COMMIT), register index constants (REG_SEC=0 … REG_TMR_HOUR=8), and the BCD digit limit 9.
- One sub-module, `bcd_check` (8-bit in, 1-bit error out, combinational), is used in READ.
- Everything else stays in the top module.

Test Plan:
- Basic scan and commit:
  - Stimulus: memory preloaded with 0x45,0x30,0x12,0x25,0x12,0x16,0,0,0; RD_LAT=1; scan_tick; frame_sync 30 cycles later.
  - Response: busy high for 18 read cycles then in PEND; updated pulses once; snapshot[7:0]=0x45 and snapshot[47:40]=0x16; bcd_err=0.
- BCD error:
  - Stimulus: address 1 holds 0x3A.
  - Response: after commit, bcd_err=9'b000000010 and snapshot[15:8]=0x3A.
- Frame gating:
  - Stimulus: memory changes sec from 0x45 to 0x46 during PEND; frame_sync pulses during READ, then again later.
  - Response: the frame_sync during READ is ignored; snapshot still shows 0x45 until the later frame_sync commits.
- Timeout:
  - Stimulus: TIMEOUT=100; no frame_sync.
  - Response: commit occurs exactly 100 cycles after entering PEND, with forced=1 and updated=1 in the same cycle.
- Pending request:
  - Stimulus: 3 scan_ticks during READ.
  - Response: after COMMIT, exactly one immediate rescan (busy stays high); then IDLE after the second commit.
- Reset mid-scan:
  - Stimulus: assert reset at idx=4.
  - Response: snapshot, bcd_err, busy, reg_addr and updated go to 0 asynchronously; a new scan_tick after release starts at reg_addr=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC snapshot scanner.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_PEND,
        ST_COMMIT
    } state_e;

    localparam int REG_SEC      = 0;
    localparam int REG_MIN      = 1;
    localparam int REG_HOUR     = 2;
    localparam int REG_DAY      = 3;
    localparam int REG_MONTH    = 4;
    localparam int REG_YEAR     = 5;
    localparam int REG_TMR_SEC  = 6;
    localparam int REG_TMR_MIN  = 7;
    localparam int REG_TMR_HOUR = 8;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/rtc_snapshot_scanner_bcd_check.sv
// Flags a byte whose upper or lower nibble is not a decimal digit.
module bcd_check
    import rtc_pkg::*;
(
    input  logic [7:0] data,
    output logic       err
);

    assign err = (data[7:4] > BCD_MAX) | (data[3:0] > BCD_MAX);

endmodule

// File: rtl/rtc_snapshot_scanner.sv
// Scans the RTC shadow registers into a work buffer and publishes it
// to the display side only on a frame boundary (or after a timeout).
module rtc_snapshot_scanner
    import rtc_pkg::*;
#(
    parameter int NUM_REGS = 9,
    parameter int RD_LAT   = 1,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_tick,
    input  logic                  frame_sync,
    output logic [3:0]            reg_addr,
    input  logic [7:0]            reg_data,
    output logic [8*NUM_REGS-1:0] snapshot,
    output logic [NUM_REGS-1:0]   bcd_err,
    output logic                  busy,
    output logic                  updated,
    output logic                  forced
);

    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [1:0]  LAT_LAST = 2'(RD_LAT);
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [3:0]            addr_q, addr_d;
    logic [1:0]            lat_q, lat_d;
    logic [19:0]           tmr_q, tmr_d;
    logic                  pend_q, pend_d;
    logic                  forced_q, forced_d;
    logic [8*NUM_REGS-1:0] work_q, work_d;
    logic [NUM_REGS-1:0]   work_err_q, work_err_d;
    logic [8*NUM_REGS-1:0] snap_q, snap_d;
    logic [NUM_REGS-1:0]   err_q, err_d;
    logic                  byte_err;

    bcd_check u_bcd_check (
        .data (reg_data),
        .err  (byte_err)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        tmr_d      = tmr_q;
        pend_d     = pend_q;
        forced_d   = forced_q;
        work_d     = work_q;
        work_err_d = work_err_q;
        snap_d     = snap_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (scan_tick) begin
                    idx_d   = 4'd0;
                    addr_d  = 4'd0;
                    lat_d   = 2'd0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                pend_d = pend_q | scan_tick;
                if (lat_q == LAT_LAST) begin
                    work_d[int'(idx_q)*8 +: 8] = reg_data;
                    work_err_d[idx_q]          = byte_err;
                    lat_d                      = 2'd0;
                    if (idx_q == LAST_IDX) begin
                        tmr_d   = 20'd0;
                        state_d = ST_PEND;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        addr_d = idx_q + 4'd1;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_PEND: begin
                pend_d = pend_q | scan_tick;
                // A frame boundary on the deadline cycle wins over the timeout
                if (frame_sync) begin
                    forced_d = 1'b0;
                    state_d  = ST_COMMIT;
                end else if (tmr_q == TMO_LAST) begin
                    forced_d = 1'b1;
                    state_d  = ST_COMMIT;
                end else begin
                    tmr_d = tmr_q + 20'd1;
                end
            end
            ST_COMMIT: begin
                snap_d   = work_q;
                err_d    = work_err_q;
                forced_d = 1'b0;
                if (pend_q | scan_tick) begin
                    pend_d  = 1'b0;
                    idx_d   = 4'd0;
                    addr_d  = 4'd0;
                    lat_d   = 2'd0;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            addr_q     <= 4'd0;
            lat_q      <= 2'd0;
            tmr_q      <= 20'd0;
            pend_q     <= 1'b0;
            forced_q   <= 1'b0;
            work_q     <= '0;
            work_err_q <= '0;
            snap_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
            tmr_q      <= tmr_d;
            pend_q     <= pend_d;
            forced_q   <= forced_d;
            work_q     <= work_d;
            work_err_q <= work_err_d;
            snap_q     <= snap_d;
            err_q      <= err_d;
        end
    end

    assign reg_addr = addr_q;
    assign snapshot = snap_q;
    assign bcd_err  = err_q;
    assign busy     = (state_q != ST_IDLE);
    assign updated  = (state_q == ST_COMMIT);
    assign forced   = forced_q;

endmodule

// File: tb/tb_rtc_snapshot_scanner.sv
// Directed bench for rtc_snapshot_scanner: a registered-read instance
// (9 regs, latency 1) and a combinational-read instance (16 regs).
module tb_rtc_snapshot_scanner;

    logic         clk = 1'b0;
    logic         reset;
    logic         scan_tick, frame_sync;
    logic [3:0]   reg_addr;
    logic [7:0]   reg_data;
    logic [71:0]  snapshot;
    logic [8:0]   bcd_err;
    logic         busy, updated, forced;

    logic         scan_tick2, frame_sync2;
    logic [3:0]   reg_addr2;
    logic [7:0]   reg_data2;
    logic [127:0] snapshot2;
    logic [15:0]  bcd_err2;
    logic         busy2, updated2, forced2;

    logic [7:0]   mem  [16];
    logic [7:0]   mem2 [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) reg_data <= mem[reg_addr];
    assign reg_data2 = mem2[reg_addr2];

    rtc_snapshot_scanner #(
        .NUM_REGS (9),
        .RD_LAT   (1),
        .TIMEOUT  (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_tick  (scan_tick),
        .frame_sync (frame_sync),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .snapshot   (snapshot),
        .bcd_err    (bcd_err),
        .busy       (busy),
        .updated    (updated),
        .forced     (forced)
    );

    rtc_snapshot_scanner #(
        .NUM_REGS (16),
        .RD_LAT   (0),
        .TIMEOUT  (100)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .scan_tick  (scan_tick2),
        .frame_sync (frame_sync2),
        .reg_addr   (reg_addr2),
        .reg_data   (reg_data2),
        .snapshot   (snapshot2),
        .bcd_err    (bcd_err2),
        .busy       (busy2),
        .updated    (updated2),
        .forced     (forced2)
    );

    typedef struct {
        logic [71:0] img;
        logic [8:0]  err;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [71:0] img);
        for (int r = 0; r < 9; r++) mem[r] = img[r*8 +: 8];
    endtask

    // Starts a scan; frame pulse driven after observing cycle frame_at.
    task automatic scan(input int frame_at, input int limit,
                        output int upd_k, output logic frc);
        int k;
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        k     = 1;
        upd_k = -1;
        frc   = 1'b0;
        while (k < limit && upd_k < 0) begin
            if (updated) begin
                upd_k = k;
                frc   = forced;
            end else begin
                frame_sync = (k == frame_at);
                step();
                frame_sync = 1'b0;
                k++;
            end
        end
        if (upd_k < 0) begin
            checks++;
            failures++;
            $display("FAIL scan_wait: got no update expected one within %0d", limit);
        end
    endtask

    initial begin
        int          uk, uk2, ucnt, bcnt;
        logic        frc;
        logic [127:0] exp2;

        vecs[0] = '{{8'h00, 8'h00, 8'h00, 8'h16, 8'h12, 8'h25, 8'h12, 8'h30, 8'h45}, 9'b000000000};
        vecs[1] = '{{8'h00, 8'h00, 8'h00, 8'h16, 8'h12, 8'h25, 8'h12, 8'h3A, 8'h45}, 9'b000000010};
        vecs[2] = '{{8'h99, 8'h9F, 8'h00, 8'h16, 8'h12, 8'h25, 8'h12, 8'h30, 8'hA0}, 9'b010000001};
        vecs[3] = '{{72{1'b1}}, 9'h1FF};
        vecs[4] = '{{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h0A, 8'h90, 8'h09}, 9'b000000100};

        for (int i = 0; i < 16; i++) begin
            mem[i]  = 8'h00;
            mem2[i] = 8'h00;
        end
        scan_tick   = 1'b0;
        frame_sync  = 1'b0;
        scan_tick2  = 1'b0;
        frame_sync2 = 1'b0;
        reset       = 1'b1;
        repeat (3) step();
        chk("rst_snapshot", snapshot, 0);
        chk("rst_bcd_err", bcd_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_updated", updated, 0);
        chk("rst_forced", forced, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_busy2", busy2, 0);
        reset = 1'b0;
        step();

        // Basic scan: address walk, busy span, single commit
        load(vecs[0].img);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        ucnt = 0;
        bcnt = 0;
        uk   = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1)  chk("basic_addr_k1", reg_addr, 0);
            if (k == 3)  chk("basic_addr_k3", reg_addr, 1);
            if (k == 17) chk("basic_addr_k17", reg_addr, 8);
            if (k == 19) chk("basic_addr_pend", reg_addr, 8);
            if (k <= 19 && busy) bcnt++;
            if (updated) begin
                ucnt++;
                uk = k;
            end
            frame_sync = (k == 30);
            step();
            frame_sync = 1'b0;
        end
        chk("basic_busy_cycles", bcnt, 19);
        chk("basic_upd_count", ucnt, 1);
        chk("basic_upd_k", uk, 31);
        chk("basic_sec", snapshot[7:0], 8'h45);
        chk("basic_year", snapshot[47:40], 8'h16);
        chk("basic_bcd_err", bcd_err, 0);
        chk("basic_idle", busy, 0);

        // Table of register images with hand-computed BCD error masks
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].img);
            scan(25, 200, uk, frc);
            chk($sformatf("tbl%0d_upd_k", i), uk, 26);
            chk($sformatf("tbl%0d_forced", i), frc, 0);
            step();
            chk($sformatf("tbl%0d_snapshot", i), snapshot, vecs[i].img);
            chk($sformatf("tbl%0d_bcd_err", i), bcd_err, vecs[i].err);
            chk($sformatf("tbl%0d_idle", i), busy, 0);
        end

        // Frame gating: early frame ignored, memory change in PEND unseen
        load(vecs[0].img);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        ucnt = 0;
        uk   = -1;
        for (int k = 1; k <= 45; k++) begin
            if (updated) begin
                ucnt++;
                uk = k;
            end
            if (k == 22) mem[0] = 8'h46;
            if (k == 30) chk("gate_hold_sec", snapshot[7:0], 8'h09);
            frame_sync = (k == 5) || (k == 40);
            step();
            frame_sync = 1'b0;
        end
        chk("gate_upd_count", ucnt, 1);
        chk("gate_upd_k", uk, 41);
        chk("gate_sec", snapshot[7:0], 8'h45);

        // Timeout without frame, then frame on the deadline cycle
        load(vecs[1].img);
        scan(-1, 300, uk, frc);
        chk("tmo_upd_k", uk, 119);
        chk("tmo_forced", frc, 1);
        step();
        chk("tmo_forced_drop", forced, 0);
        chk("tmo_snapshot", snapshot, vecs[1].img);
        load(vecs[0].img);
        scan(118, 300, uk, frc);
        chk("dl_upd_k", uk, 119);
        chk("dl_forced", frc, 0);
        step();

        // Pending requests: three ticks in READ give one rescan
        load(vecs[0].img);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        ucnt = 0;
        bcnt = 0;
        uk   = -1;
        uk2  = -1;
        for (int k = 1; k <= 70; k++) begin
            if (k <= 51 && !busy) bcnt++;
            if (k == 27) chk("pend_restart_addr", reg_addr, 0);
            if (k == 52) chk("pend_final_idle", busy, 0);
            if (updated) begin
                ucnt++;
                if (uk < 0) uk = k;
                else uk2 = k;
            end
            scan_tick  = (k == 3) || (k == 5) || (k == 7);
            frame_sync = (k == 25) || (k == 50);
            step();
            scan_tick  = 1'b0;
            frame_sync = 1'b0;
        end
        chk("pend_busy_gaps", bcnt, 0);
        chk("pend_upd_count", ucnt, 2);
        chk("pend_upd1_k", uk, 26);
        chk("pend_upd2_k", uk2, 51);

        // Reset at idx 4
        load(vecs[2].img);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        repeat (8) step();
        chk("mid_addr_before", reg_addr, 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_snapshot", snapshot, 0);
        chk("mid_rst_bcd_err", bcd_err, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", reg_addr, 0);
        chk("mid_rst_updated", updated, 0);
        step();
        reset = 1'b0;
        step();
        scan(25, 200, uk, frc);
        chk("mid_rescan_upd_k", uk, 26);
        step();
        chk("mid_rescan_snapshot", snapshot, vecs[2].img);

        // Sixteen registers, zero read latency, index wrap
        exp2 = '0;
        for (int i = 0; i < 16; i++) begin
            mem2[i]         = 8'h10 + 8'(i);
            exp2[i*8 +: 8]  = 8'h10 + 8'(i);
        end
        scan_tick2 = 1'b1;
        step();
        scan_tick2 = 1'b0;
        uk2 = -1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 16) chk("w16_last_addr", reg_addr2, 15);
            if (updated2 && uk2 < 0) uk2 = k;
            frame_sync2 = (k == 20);
            step();
            frame_sync2 = 1'b0;
        end
        chk("w16_upd_k", uk2, 21);
        chk("w16_snapshot", snapshot2, exp2);
        chk("w16_bcd_err", bcd_err2, 16'hFC00);
        chk("w16_addr_hold", reg_addr2, 15);
        chk("w16_idle", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
